// File: rtl/gated_register_pkg.sv
// Common constants shared by the gated_register block and its users.
package gated_register_pkg;

  // Project-wide default datapath width.
  localparam int DATA_WIDTH = 8;

endpackage : gated_register_pkg

// File: rtl/gated_register.sv
// gated_register: one stored word with a write enable and an output enable.
// The stored word is presented on o_w_out only while i_w_oe is high; otherwise
// the output is driven to zero so a higher level can OR/mux several cells onto
// a shared read bus without tri-states.
module gated_register
  import gated_register_pkg::*;
#(
  parameter int p_data_width = DATA_WIDTH
) (
  input  logic                    i_w_clk,
  input  logic                    i_w_reset,
  input  logic [p_data_width-1:0] i_w_in,
  input  logic                    i_w_we,
  input  logic                    i_w_oe,
  output logic [p_data_width-1:0] o_w_out
);

  logic [p_data_width-1:0] r_data;

  // Storage: reset has priority over a write, otherwise hold.
  always_ff @(posedge i_w_clk) begin
    if (i_w_reset) begin
      r_data <= '0;
    end else if (i_w_we) begin
      r_data <= i_w_in;
    end
  end

  // Output gating is combinational so i_w_oe acts with zero latency.
  assign o_w_out = i_w_oe ? r_data : '0;

endmodule : gated_register

// File: tb/tb_gated_register.sv
// Bench for gated_register: directed vectors, expected values pushed into a
// scoreboard queue by the stimulus and checked by an independent monitor.
`timescale 1ns/100ps
module tb_gated_register;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic [W-1:0] din;
  logic         we;
  logic         oe;
  logic [W-1:0] dout;

  typedef struct {
    string        name;
    logic [W-1:0] exp;
  } exp_t;

  exp_t exp_q[$];
  int   checks;
  int   errors;
  logic [W-1:0] model_last;

  gated_register #(.p_data_width(W)) dut (
    .i_w_clk  (clk),
    .i_w_reset(rst),
    .i_w_in   (din),
    .i_w_we   (we),
    .i_w_oe   (oe),
    .o_w_out  (dout)
  );

  initial clk = 1'b0;
  always #2 clk = ~clk;

  // Apply inputs, then wait for one rising edge and settle past it.
  task automatic step(input logic r, input logic w, input logic o, input logic [W-1:0] d);
    rst = r;
    we  = w;
    oe  = o;
    din = d;
    @(posedge clk);
    #1;
  endtask

  // Queue an expectation for the monitor; hold inputs while it samples.
  task automatic expect_out(input string name, input logic [W-1:0] e);
    exp_t item;
    item.name = name;
    item.exp  = e;
    exp_q.push_back(item);
    #0.5;
  endtask

  // Monitor: whenever an expectation is pending, sample the output and compare.
  initial begin
    checks = 0;
    errors = 0;
    forever begin
      wait (exp_q.size() != 0);
      #0.2;
      checks++;
      if (dout !== exp_q[0].exp) begin
        errors++;
        $display("FAIL %s: o_w_out=%0h expected=%0h", exp_q[0].name, dout, exp_q[0].exp);
      end else begin
        $display("ok   %s: o_w_out=%0h", exp_q[0].name, dout);
      end
      void'(exp_q.pop_front());
    end
  end

  // Stimulus
  initial begin
    rst = 1'b1; we = 1'b1; oe = 1'b1; din = 8'd3;

    // 1. Reset held for two edges beats a pending write
    step(1'b1, 1'b1, 1'b1, 8'd3); expect_out("reset_edge1", 8'd0);
    step(1'b1, 1'b1, 1'b1, 8'd3); expect_out("reset_edge2", 8'd0);

    // 2. Write / read with one-cycle latency
    step(1'b0, 1'b1, 1'b1, 8'd2); expect_out("write_2", 8'd2);
    step(1'b0, 1'b1, 1'b1, 8'd3); expect_out("write_3", 8'd3);

    // 3. Hold with we low
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b1, 8'd2);
      expect_out($sformatf("hold_%0d", i), 8'd3);
    end

    // 4. Hidden write, then oe raised with no clock edge
    step(1'b0, 1'b1, 1'b0, 8'd2); expect_out("hidden_write", 8'd0);
    we = 1'b0;
    oe = 1'b1;
    expect_out("oe_zero_latency", 8'd2);

    // 5. Mid-operation reset discards the pending write
    step(1'b0, 1'b1, 1'b1, 8'd3); expect_out("preload_3", 8'd3);
    step(1'b1, 1'b1, 1'b1, 8'd2); expect_out("mid_reset", 8'd0);
    step(1'b0, 1'b1, 1'b1, 8'd2); expect_out("post_reset_write", 8'd2);

    // 6. Sweep oe x we x in, two edges each, against a reference model
    model_last = 8'd2;
    for (int o = 0; o < 2; o++) begin
      for (int w = 0; w < 2; w++) begin
        for (int d = 2; d < 4; d++) begin
          for (int e = 0; e < 2; e++) begin
            step(1'b0, w[0], o[0], W'(d));
            if (w != 0) model_last = W'(d);
            expect_out($sformatf("sweep_oe%0d_we%0d_in%0d_e%0d", o, w, d, e),
                       (o != 0) ? model_last : 8'd0);
          end
        end
      end
    end

    // Drain the scoreboard with a bounded wait
    for (int k = 0; k < 100 && exp_q.size() != 0; k++) #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: pending=%0d expected=0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_gated_register
